// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, mux selects, ALU ops, FSM states and control bundle shared by the BIP control unit
package bip_pkg;
    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [1:0] SELA_MEM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ALU = 2'd2;
    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_IMM = 1'b1;
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;
endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode-to-control table
// ports: opcode in, ctrl out (selects/strobes), hlt out (HLT opcode), illegal out (unknown opcode)
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] opcode,
    output ctrl_t      ctrl,
    output logic       hlt,
    output logic       illegal
);
    logic alu;
    assign alu          = opcode inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI};
    assign ctrl.sel_a   = alu ? SELA_ALU : (opcode == OP_LDI) ? SELA_IMM : SELA_MEM;
    assign ctrl.sel_b   = (opcode inside {OP_ADDI, OP_SUBI}) ? SELB_IMM : SELB_MEM;
    assign ctrl.op      = (opcode inside {OP_SUB, OP_SUBI}) ? ALU_SUB : ALU_ADD;
    assign ctrl.wr_acc  = alu || (opcode inside {OP_LD, OP_LDI});
    assign ctrl.wr_ram  = opcode == OP_STO;
    assign ctrl.rd_ram  = opcode inside {OP_LD, OP_ADD, OP_SUB};
    assign hlt          = opcode == OP_HLT;
    assign illegal      = opcode > OP_SUBI;
endmodule

// File: rtl/bip_control.sv
// bip_control: BIP fetch/exec sequencer with PC, instruction counter, illegal flag and gated decode strobes
// ports: i_clk, i_rst_n (async low), i_start pulse, i_INSTR (sync ROM data);
//        o_PC, o_ADDR, o_SIGNAL (sign-extended operand), o_selA/o_selB/o_op, o_wrAcc/o_wrRam/o_rdRam,
//        o_halted, o_illegal (sticky), o_count (saturating)
module bip_control
    import bip_pkg::*;
#(
    parameter int PC_WIDTH     = 11,
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_INSTR,
    output logic [PC_WIDTH-1:0]   o_PC,
    output logic [PC_WIDTH-1:0]   o_ADDR,
    output logic [DATA_WIDTH-1:0] o_SIGNAL,
    output logic [1:0]            o_selA,
    output logic                  o_selB,
    output logic                  o_op,
    output logic                  o_wrAcc,
    output logic                  o_wrRam,
    output logic                  o_rdRam,
    output logic                  o_halted,
    output logic                  o_illegal,
    output logic [15:0]           o_count
);
    state_t state;
    ctrl_t  dec, ctrl;
    logic   dec_hlt, dec_illegal;

    bip_decoder u_dec (
        .opcode  (i_INSTR[DATA_WIDTH-1 -: OPCODE_WIDTH]),
        .ctrl    (dec),
        .hlt     (dec_hlt),
        .illegal (dec_illegal)
    );

    // gating on state keeps strobes low outside EXEC, and async reset drops them instantly
    assign ctrl     = (state == S_EXEC) ? dec : '0;
    assign o_selA   = ctrl.sel_a;
    assign o_selB   = ctrl.sel_b;
    assign o_op     = ctrl.op;
    assign o_wrAcc  = ctrl.wr_acc;
    assign o_wrRam  = ctrl.wr_ram;
    assign o_rdRam  = ctrl.rd_ram;
    assign o_ADDR   = i_INSTR[PC_WIDTH-1:0];
    assign o_SIGNAL = {{(DATA_WIDTH-PC_WIDTH){i_INSTR[PC_WIDTH-1]}}, i_INSTR[PC_WIDTH-1:0]};
    assign o_halted = state == S_HALT;

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            state     <= S_IDLE;
            o_PC      <= '0;
            o_count   <= '0;
            o_illegal <= 1'b0;
        end else
            case (state)
                S_IDLE, S_HALT:
                    if (i_start) begin
                        state     <= S_FETCH;
                        o_PC      <= '0;
                        o_count   <= '0;
                        o_illegal <= 1'b0;
                    end
                S_FETCH: state <= S_EXEC;
                S_EXEC:
                    if (dec_hlt)
                        state <= S_HALT;
                    else begin
                        state     <= S_FETCH;
                        o_PC      <= o_PC + PC_WIDTH'(1);
                        o_count   <= (o_count == 16'hFFFF) ? o_count : o_count + 16'd1;
                        o_illegal <= o_illegal | dec_illegal;
                    end
                default: state <= S_IDLE;
            endcase
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: scoreboard bench for bip_control with a synchronous ROM model
module tb_bip_control;
    import bip_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] instr = 16'h0;
    logic [10:0] o_pc, o_addr;
    logic [15:0] o_signal, o_count;
    logic [1:0]  o_sela;
    logic        o_selb, o_op, o_wracc, o_wrram, o_rdram, o_halted, o_illegal;
    logic [15:0] rom [0:2047];
    logic [44:0] sb [$];
    logic        sb_en = 1'b0;
    int          tests = 0, errors = 0;

    bip_control dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_INSTR(instr),
        .o_PC(o_pc), .o_ADDR(o_addr), .o_SIGNAL(o_signal),
        .o_selA(o_sela), .o_selB(o_selb), .o_op(o_op),
        .o_wrAcc(o_wracc), .o_wrRam(o_wrram), .o_rdRam(o_rdram),
        .o_halted(o_halted), .o_illegal(o_illegal), .o_count(o_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) instr <= rom[o_pc];

    function automatic logic [44:0] model(input logic [10:0] pc, input logic [15:0] ins);
        logic [1:0] sa;
        logic sbb, op, wa, wr, rr;
        sa = 2'd0; sbb = 1'b0; op = 1'b0; wa = 1'b0; wr = 1'b0; rr = 1'b0;
        case (ins[15:11])
            5'd1: wr = 1'b1;
            5'd2: begin rr = 1'b1; wa = 1'b1; end
            5'd3: begin sa = 2'd1; wa = 1'b1; end
            5'd4: begin rr = 1'b1; sa = 2'd2; wa = 1'b1; end
            5'd5: begin sa = 2'd2; sbb = 1'b1; wa = 1'b1; end
            5'd6: begin rr = 1'b1; sa = 2'd2; op = 1'b1; wa = 1'b1; end
            5'd7: begin sa = 2'd2; sbb = 1'b1; op = 1'b1; wa = 1'b1; end
            default: ;
        endcase
        return {pc, sa, sbb, op, wa, wr, rr, ins[10:0], {{5{ins[10]}}, ins[10:0]}};
    endfunction

    always @(negedge clk) begin
        logic [44:0] act, exp_v;
        if (rst_n && sb_en && dut.state == S_EXEC) begin
            tests++;
            act = {o_pc, o_sela, o_selb, o_op, o_wracc, o_wrram, o_rdram, o_addr, o_signal};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: unexpected EXEC at pc=%0d", o_pc);
            end else begin
                exp_v = sb.pop_front();
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL exec_decode: got=%h expected=%h", act, exp_v);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_prog(input int n);
        for (int i = 0; i < n; i++) sb.push_back(model(11'(i), rom[i]));
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 5000 && !o_halted; i++) tick();
        tests++;
        if (!o_halted) begin
            errors++;
            $display("FAIL %s_halt_timeout: halted=%b required 1", name, o_halted);
        end
        tests++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_left: %0d entries remain, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0;
        tick();
        tests++;
        if ({o_pc, o_count, o_illegal, o_halted, o_sela, o_selb, o_op, o_wracc, o_wrram, o_rdram} !== '0) begin
            errors++;
            $display("FAIL reset_state: outputs nonzero pc=%0d count=%0d", o_pc, o_count);
        end
        rst_n = 1'b1;
        rom[0] = 16'h2803;
        tick();
        pulse_start();
        tick();
        tests++;
        if ({o_wracc, o_selb, o_sela} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_addi_exec: wrAcc/selB/selA=%b required 1110", {o_wracc, o_selb, o_sela});
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({o_pc, o_count, o_illegal, o_halted, o_sela, o_selb, o_op, o_wracc, o_wrram, o_rdram} !== '0) begin
            errors++;
            $display("FAIL reset_async: wrAcc=%b selB=%b selA=%0d pc=%0d required all 0", o_wracc, o_selb, o_sela, o_pc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tests++;
        if (dut.state !== S_IDLE || o_pc !== 11'd0 || o_wracc !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: state=%0d pc=%0d required IDLE, 0", dut.state, o_pc);
        end
    endtask

    task automatic test_program;
        rom[0] = 16'h1805; rom[1] = 16'h2803; rom[2] = 16'h0802; rom[3] = 16'h0000;
        push_prog(4);
        sb_en = 1'b1;
        pulse_start();
        tick();
        tests++;
        if (o_sela !== 2'd1 || o_wracc !== 1'b1 || o_signal !== 16'h0005) begin
            errors++;
            $display("FAIL prog_ldi: selA=%0d wrAcc=%b signal=%h required 1 1 0005", o_sela, o_wracc, o_signal);
        end
        wait_halt("prog");
        tests++;
        if (o_count !== 16'd3 || o_pc !== 11'd3 || {o_wracc, o_wrram, o_rdram} !== 3'b000) begin
            errors++;
            $display("FAIL prog_end: count=%0d pc=%0d strobes=%b required 3 3 000", o_count, o_pc, {o_wracc, o_wrram, o_rdram});
        end
    endtask

    task automatic test_sign_ext;
        rom[0] = 16'h3FFF; rom[1] = 16'h2BFF; rom[2] = 16'h0000;
        push_prog(3);
        pulse_start();
        tick();
        tests++;
        if (o_signal !== 16'hFFFF || o_selb !== 1'b1 || o_op !== 1'b1) begin
            errors++;
            $display("FAIL sign_neg: signal=%h selB=%b op=%b required FFFF 1 1", o_signal, o_selb, o_op);
        end
        tick();
        tick();
        tests++;
        if (o_signal !== 16'h03FF) begin
            errors++;
            $display("FAIL sign_pos: signal=%h required 03FF", o_signal);
        end
        wait_halt("sign");
    endtask

    task automatic test_mem_operands;
        rom[0] = 16'h2007; rom[1] = 16'h3007; rom[2] = 16'h0000;
        push_prog(3);
        pulse_start();
        tick();
        tests++;
        if ({o_rdram, o_selb, o_op} !== 3'b100 || o_addr !== 11'd7) begin
            errors++;
            $display("FAIL mem_add: rdRam/selB/op=%b addr=%0d required 100 7", {o_rdram, o_selb, o_op}, o_addr);
        end
        wait_halt("mem");
    endtask

    task automatic test_illegal_restart;
        rom[0] = 16'hF800; rom[1] = 16'h0000;
        push_prog(2);
        pulse_start();
        wait_halt("ill");
        tests++;
        if (o_illegal !== 1'b1 || o_pc !== 11'd1 || o_count !== 16'd1) begin
            errors++;
            $display("FAIL ill_flag: illegal=%b pc=%0d count=%0d required 1 1 1", o_illegal, o_pc, o_count);
        end
        rom[0] = 16'h1809;
        push_prog(2);
        pulse_start();
        tests++;
        if (o_illegal !== 1'b0 || o_pc !== 11'd0 || o_count !== 16'd0 || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: illegal=%b pc=%0d count=%0d halted=%b required 0 0 0 0", o_illegal, o_pc, o_count, o_halted);
        end
        wait_halt("restart");
        tests++;
        if (o_count !== 16'd1 || o_illegal !== 1'b0) begin
            errors++;
            $display("FAIL restart_end: count=%0d illegal=%b required 1 0", o_count, o_illegal);
        end
    endtask

    task automatic test_wrap_mask;
        sb_en = 1'b0;
        for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;
        start = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0;
        tests++;
        if (o_pc !== 11'd1 || o_count !== 16'd1 || dut.state !== S_FETCH) begin
            errors++;
            $display("FAIL start_mask: pc=%0d count=%0d state=%0d required 1 1 FETCH", o_pc, o_count, dut.state);
        end
        rom[0] = 16'h0000;
        wait_halt("wrap");
        tests++;
        if (o_pc !== 11'd0 || o_count !== 16'd2048 || o_illegal !== 1'b1) begin
            errors++;
            $display("FAIL wrap: pc=%0d count=%0d illegal=%b required 0 2048 1", o_pc, o_count, o_illegal);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_sign_ext();
        test_mem_operands();
        test_illegal_restart();
        test_wrap_mask();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/bip_control.md
# bip_control

Control unit of the BIP accumulator processor: fetches each instruction from program memory, decodes it, and drives the datapath strobes. These include `o_selB`, the select consumed by the operand-B mux (0 = data memory word, 1 = sign-extended immediate). It also owns the program counter, sign-extends the 11-bit operand onto `o_SIGNAL`, and sequences run/halt for the top level and debug unit.

## Interface
- `PC_WIDTH`, 11: program counter and operand width.
- `DATA_WIDTH`, 16: datapath width (`o_SIGNAL`).
- `OPCODE_WIDTH`, 5: opcode field, instruction bits [15:11].
- `i_clk` in 1: single clock; all state updates on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: one-cycle pulse; starts execution from PC 0 when in IDLE or HALT.
- `i_INSTR` in 16: program memory read data. Synchronous ROM, valid the cycle after `o_PC` is presented.
- `o_PC` out `PC_WIDTH`: program memory address.
- `o_ADDR` out `PC_WIDTH`: data memory address, equal to `i_INSTR[10:0]`.
- `o_SIGNAL` out `DATA_WIDTH`: `i_INSTR[10:0]` sign-extended.
- `o_selA` out 2: accumulator source. 0 = data memory, 1 = `o_SIGNAL`, 2 = ALU.
- `o_selB` out 1: operand-B source. 0 = data memory, 1 = `o_SIGNAL`.
- `o_op` out 1: ALU operation. 0 = add, 1 = sub.
- `o_wrAcc`, `o_wrRam`, `o_rdRam` out 1: one-cycle strobes.
- `o_halted` out 1: high in HALT.
- `o_illegal` out 1: sticky unknown-opcode flag.
- `o_count` out 16: instructions executed since the last start; saturates.

## Operation
- States are IDLE, FETCH, EXEC, HALT. The reset state is IDLE.
- **IDLE:** on `i_start`, clear PC, `o_count` and `o_illegal`, then go to FETCH.
- **FETCH:** present `o_PC`; unconditionally go to EXEC.
- **EXEC:** decode `i_INSTR[15:11]` and assert the strobes below for this cycle only.
  - Non-HLT opcodes: PC <= PC+1, `o_count`++, go to FETCH.
  - HLT: PC unchanged, count unchanged, go to HALT.
- Decode table (signals not listed are 0):
  - 00000 HLT: no strobes.
  - 00001 STO: `wrRam`.
  - 00010 LD: `rdRam`, `selA`=0, `wrAcc`.
  - 00011 LDI: `selA`=1, `wrAcc`.
  - 00100 ADD: `rdRam`, `selA`=2, `selB`=0, `op`=0, `wrAcc`.
  - 00101 ADDI: `selA`=2, `selB`=1, `op`=0, `wrAcc`.
  - 00110 SUB: `rdRam`, `selA`=2, `selB`=0, `op`=1, `wrAcc`.
  - 00111 SUBI: `selA`=2, `selB`=1, `op`=1, `wrAcc`.
  - Other: no strobes, set `o_illegal`, treat as NOP (PC advances, count increments).
- **HALT:** `o_halted`=1 and all strobes 0. `i_start` restarts exactly as from IDLE.
- `i_start` is ignored in FETCH and EXEC.
- **PC wrap-around:** PC+1 wraps modulo 2^`PC_WIDTH`; no flag is raised.
- **Count saturation:** `o_count` holds at 0xFFFF.

## Timing
- **Reset values:** state IDLE, `o_PC`=0, `o_count`=0, `o_illegal`=0, `o_halted`=0, and all strobes/selects 0.
- **Throughput:** one instruction per 2 cycles (FETCH, EXEC).
- `i_start` is seen at edge N; the first FETCH is cycle N+1 and the first EXEC is cycle N+2.
- **Decoded outputs:** strobes, selects, `o_ADDR` and `o_SIGNAL` are combinational from state and `i_INSTR`. They are valid only in EXEC; strobes are forced to 0 outside EXEC.
- **Datapath contract:**
  - The accumulator and data RAM capture on the edge ending EXEC.
  - Data memory read is asynchronous, so `i_DATA` is valid in EXEC.
- **Reset mid-operation:** reset asserted in any state returns to IDLE immediately, with strobes deasserted asynchronously.

## Structure
- Shared package `bip_pkg` holds:
  - Opcode constants: `OP_HLT` through `OP_SUBI`.
  - `SELA_MEM`/`SELA_IMM`/`SELA_ALU` and `SELB_MEM`/`SELB_IMM`.
  - `ALU_ADD`/`ALU_SUB`.
  - State encoding.
- Sub-module `bip_decoder`: a purely combinational opcode-to-control-signal table, reusable by the debug unit's disassembler.
- The FSM, PC, counter and sticky flag stay in `bip_control`.

## Test plan
- **Reset:** reset low mid-EXEC of ADDI -> all outputs read 0 immediately and the state is IDLE after release.
- **Program run:** program LDI 5; ADDI 3; STO 2; HLT, then start ->
  - LDI EXEC: `selA`=1, `wrAcc`=1, `o_SIGNAL`=0x0005.
  - ADDI EXEC: `selB`=1, `op`=0.
  - STO EXEC: `wrRam`=1, `o_ADDR`=2.
  - Then `o_halted`=1, `o_count`=3, PC held at 3.
- **Sign extension:** SUBI with immediate 0x7FF -> `o_SIGNAL`=0xFFFF, `selB`=1, `op`=1. Immediate 0x3FF -> `o_SIGNAL`=0x03FF.
- **Memory operands:** ADD 7 and SUB 7 -> `rdRam`=1, `selB`=0, `o_ADDR`=7, `op` 0 and 1 respectively.
- **Illegal opcode and restart:** opcode 11111 -> no strobes, `o_illegal`=1, PC advances. A later `i_start` in HALT clears the flag and restarts from PC 0.
- **Wrap-around and start masking:** 2048 NOPs (illegal) from PC 0 -> PC wraps to 0. `i_start` pulsed during FETCH/EXEC -> ignored.
